// File: rtl/data_sram_axi_bridge.sv
// data_sram_axi_bridge
//
// Purpose:
//   Converts the CPU data port (req / addr_ok / data_ok SRAM-like handshake)
//   into single-beat AXI master transactions. The bridge handles one
//   transaction at a time. It stalls the core by holding data_addr_ok low
//   until the current transaction has finished.
//
// Ports:
//   clk, resetn            clock; asynchronous active-low reset
//   data_req .. data_wdata CPU request side (inputs)
//   data_addr_ok           request accepted this cycle (high only in IDLE)
//   data_data_ok           one-cycle completion pulse
//   data_rdata             read data, valid with data_data_ok, held afterwards
//   ar* / r*               AXI read address and read data channels
//   aw* / w* / b*          AXI write address, write data and write response
//                          channels
module data_sram_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  // CPU data port
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  // AXI read address / data
  output logic [ADDR_W-1:0]   araddr,
  output logic [7:0]          arlen,
  output logic [2:0]          arsize,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  // AXI write address / data / response
  output logic [ADDR_W-1:0]   awaddr,
  output logic [7:0]          awlen,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int LANE_W = OFF_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                arvalid_q, arvalid_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                rready_q, rready_d;
  logic                bready_q, bready_d;
  logic                data_ok_q, data_ok_d;

  // R beats are always single-beat, so rlast carries no information here.
  logic unused_rlast;
  assign unused_rlast = rlast;

  // ------------------------------------------------------------------
  // Byte-strobe generation for the incoming request.
  // The access window has 1, 2 or 4 bytes. It starts at the byte offset
  // rounded down to the access size. Size 3 is treated as a word access.
  // ------------------------------------------------------------------
  logic [LANE_W-1:0] acc_bytes;
  logic [LANE_W-1:0] lane_base;
  logic [STRB_W-1:0] strb_calc;

  always_comb begin
    acc_bytes = LANE_W'(4);
    case (data_size)
      2'd0:    acc_bytes = LANE_W'(1);
      2'd1:    acc_bytes = LANE_W'(2);
      default: acc_bytes = LANE_W'(4);
    endcase
  end

  assign lane_base = {1'b0, data_addr[OFF_W-1:0]} & ~(acc_bytes - LANE_W'(1));

  generate
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
      assign strb_calc[gi] = (LANE_W'(gi) >= lane_base) &&
                             (LANE_W'(gi) <  (lane_base + acc_bytes));
    end
  endgenerate

  // ------------------------------------------------------------------
  // Next-state logic. The valid and ready outputs are registered from the
  // next state, so each one is high for exactly the cycles spent in its
  // state.
  // ------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_req) begin
          addr_d  = data_addr;
          size_d  = data_size;
          wdata_d = data_wdata;
          wstrb_d = strb_calc;
          if (data_wr) begin
            state_d   = WR_REQ;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d = RD_ADDR;
          end
        end
      end
      RD_ADDR: begin
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (rvalid) begin
          rdata_d = rdata;
          state_d = DONE;
        end
      end
      WR_REQ: begin
        // AW and W retire independently. Each valid drops after its own
        // handshake. The state moves on once neither valid is pending.
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (bvalid) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    arvalid_d = (state_d == RD_ADDR);
    rready_d  = (state_d == RD_DATA);
    bready_d  = (state_d == WR_RESP);
    data_ok_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      rready_q  <= 1'b0;
      bready_q  <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      arvalid_q <= arvalid_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      rready_q  <= rready_d;
      bready_q  <= bready_d;
      data_ok_q <= data_ok_d;
    end
  end

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  assign data_addr_ok = (state_q == IDLE);
  assign data_data_ok = data_ok_q;
  assign data_rdata   = rdata_q;

  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awvalid = awvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

endmodule

// File: tb/tb_data_sram_axi_bridge.sv
// Directed testbench for data_sram_axi_bridge. Outputs are sampled 1 ns
// after the rising edge, and inputs are changed at the same point.
module tb_data_sram_axi_bridge;

  logic        clk;
  logic        resetn;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic        bready;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  data_sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .araddr       (araddr),
    .arlen        (arlen),
    .arsize       (arsize),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready),
    .awaddr       (awaddr),
    .awlen        (awlen),
    .awsize       (awsize),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wstrb        (wstrb),
    .wlast        (wlast),
    .wvalid       (wvalid),
    .wready       (wready),
    .bvalid       (bvalid),
    .bready       (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
      $display("check %-20s got=%0h exp=%0h ok", tag, got, exp);
    end else begin
      $display("FAIL %-20s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait read: AR is ready at once and R returns in the next cycle.
  task automatic read_zw(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] rd);
    data_req = 1'b1; data_wr = 1'b0; data_addr = a; data_size = sz;
    check("rd_accept_addr_ok", data_addr_ok, 1'b1);
    tick();
    data_req = 1'b0;
    check("rd_arvalid", arvalid, 1'b1);
    check("rd_araddr", araddr, a);
    check("rd_arsize", arsize, {1'b0, sz});
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("rd_rready", rready, 1'b1);
    rvalid = 1'b1; rdata = rd;
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    check("rd_data_ok", data_data_ok, 1'b1);
    check("rd_data_rdata", data_rdata, rd);
    tick();
    check("rd_end_data_ok", data_data_ok, 1'b0);
    check("rd_end_addr_ok", data_addr_ok, 1'b1);
  endtask

  // Zero-wait write: AW and W are both ready in the first cycle and B follows.
  task automatic write_zw(input logic [31:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, input logic [3:0] exp_strb);
    data_req = 1'b1; data_wr = 1'b1; data_addr = a; data_size = sz; data_wdata = wd;
    tick();
    data_req = 1'b0;
    check("wr_awvalid", awvalid, 1'b1);
    check("wr_wvalid", wvalid, 1'b1);
    check("wr_wstrb", wstrb, exp_strb);
    check("wr_wdata", wdata, wd);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    check("wr_bready", bready, 1'b1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("wr_data_ok", data_data_ok, 1'b1);
    tick();
    check("wr_end_addr_ok", data_addr_ok, 1'b1);
  endtask

  initial begin
    resetn = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0;
    data_addr = 32'h0; data_wdata = 32'h0;
    arready = 1'b0; rdata = 32'h0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

    // ---------------- reset ----------------
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_addr_ok", data_addr_ok, 1'b1);
    check("rst_data_ok", data_data_ok, 1'b0);
    check("rst_rdata", data_rdata, 32'h0);

    // ---------------- word read, R three cycles after AR ----------------
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1FC0_0010; data_size = 2'd2;
    check("wr0_accept", data_addr_ok, 1'b1);
    tick();
    data_req = 1'b0;
    check("word_rd_arvalid", arvalid, 1'b1);
    check("word_rd_araddr", araddr, 32'h1FC0_0010);
    check("word_rd_arsize", arsize, 3'b010);
    check("word_rd_arlen", arlen, 8'd0);
    check("word_rd_addr_ok_lo", data_addr_ok, 1'b0);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("word_rd_arvalid_drop", arvalid, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("word_rd_rready", rready, 1'b1);
      check("word_rd_no_data_ok", data_data_ok, 1'b0);
      tick();
    end
    check("word_rd_rready_last", rready, 1'b1);
    rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    tick();
    rvalid = 1'b0; rdata = 32'h0;
    check("word_rd_data_ok", data_data_ok, 1'b1);
    check("word_rd_rdata", data_rdata, 32'hDEAD_BEEF);
    check("word_rd_done_addr_ok", data_addr_ok, 1'b0);
    check("word_rd_done_rready", rready, 1'b0);
    tick();
    check("word_rd_pulse_end", data_data_ok, 1'b0);
    check("word_rd_idle_addr_ok", data_addr_ok, 1'b1);
    check("word_rd_rdata_hold", data_rdata, 32'hDEAD_BEEF);

    // ---------------- byte write, B delayed one cycle ----------------
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_0003; data_size = 2'd0;
    data_wdata = 32'hAB00_0000;
    tick();
    data_req = 1'b0;
    check("byte_wr_awvalid", awvalid, 1'b1);
    check("byte_wr_wvalid", wvalid, 1'b1);
    check("byte_wr_awaddr", awaddr, 32'h8000_0003);
    check("byte_wr_awsize", awsize, 3'b000);
    check("byte_wr_awlen", awlen, 8'd0);
    check("byte_wr_wstrb", wstrb, 4'b1000);
    check("byte_wr_wlast", wlast, 1'b1);
    check("byte_wr_wdata", wdata, 32'hAB00_0000);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    check("byte_wr_aw_drop", awvalid, 1'b0);
    check("byte_wr_w_drop", wvalid, 1'b0);
    check("byte_wr_bready", bready, 1'b1);
    tick();
    check("byte_wr_bready_wait", bready, 1'b1);
    check("byte_wr_no_data_ok", data_data_ok, 1'b0);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("byte_wr_data_ok", data_data_ok, 1'b1);
    check("byte_wr_bready_drop", bready, 1'b0);
    check("byte_wr_rdata_hold", data_rdata, 32'hDEAD_BEEF);
    tick();
    check("byte_wr_idle", data_addr_ok, 1'b1);

    // ---------------- halfword write, wready delayed 4 cycles ----------------
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_0012; data_size = 2'd1;
    data_wdata = 32'hBEEF_0000;
    tick();
    data_req = 1'b0; data_wdata = 32'h0;
    check("hw_wr_awvalid", awvalid, 1'b1);
    check("hw_wr_wvalid_c1", wvalid, 1'b1);
    check("hw_wr_wstrb", wstrb, 4'b1100);
    check("hw_wr_awsize", awsize, 3'b001);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      check("hw_wr_aw_low", awvalid, 1'b0);
      check("hw_wr_wvalid_held", wvalid, 1'b1);
      check("hw_wr_wdata_stable", wdata, 32'hBEEF_0000);
      check("hw_wr_bready_low", bready, 1'b0);
      if (i == 5) wready = 1'b1;
      tick();
    end
    wready = 1'b0;
    check("hw_wr_w_drop", wvalid, 1'b0);
    check("hw_wr_bready", bready, 1'b1);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check("hw_wr_data_ok", data_data_ok, 1'b1);
    tick();

    // ---------------- strobe corners ----------------
    write_zw(32'h8000_0101, 2'd0, 32'h0000_5A00, 4'b0010);
    write_zw(32'h8000_0200, 2'd2, 32'h0102_0304, 4'b1111);
    write_zw(32'h8000_0301, 2'd1, 32'h0000_CAFE, 4'b0011);
    write_zw(32'h8000_0402, 2'd3, 32'h1111_2222, 4'b1111);

    // ---------------- back-to-back reads ----------------
    arready = 1'b1;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1000_0010; data_size = 2'd2;
    tick();
    data_addr = 32'h1000_0020;            // second request, held until accepted
    check("b2b_ar1", arvalid, 1'b1);
    check("b2b_ar1_addr", araddr, 32'h1000_0010);
    tick();
    check("b2b_c2_arvalid", arvalid, 1'b0);
    check("b2b_c2_addr_ok", data_addr_ok, 1'b0);
    rvalid = 1'b1; rdata = 32'h1111_1111;
    tick();
    rvalid = 1'b0;
    check("b2b_data_ok1", data_data_ok, 1'b1);
    check("b2b_rdata1", data_rdata, 32'h1111_1111);
    check("b2b_c3_arvalid", arvalid, 1'b0);
    check("b2b_c3_addr_ok", data_addr_ok, 1'b0);
    tick();
    check("b2b_accept2", data_addr_ok, 1'b1);
    check("b2b_c4_arvalid", arvalid, 1'b0);
    check("b2b_c4_data_ok", data_data_ok, 1'b0);
    tick();
    data_req = 1'b0;
    check("b2b_ar2", arvalid, 1'b1);
    check("b2b_ar2_addr", araddr, 32'h1000_0020);
    tick();
    rvalid = 1'b1; rdata = 32'h2222_2222;
    tick();
    rvalid = 1'b0;
    arready = 1'b0;
    check("b2b_data_ok2", data_data_ok, 1'b1);
    check("b2b_rdata2", data_rdata, 32'h2222_2222);
    tick();

    // ---------------- reset during RD_DATA ----------------
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1FC0_0080; data_size = 2'd2;
    tick();
    data_req = 1'b0;
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("mid_rst_rready_pre", rready, 1'b1);
    resetn = 1'b0;
    #1;
    check("mid_rst_rready", rready, 1'b0);
    check("mid_rst_arvalid", arvalid, 1'b0);
    check("mid_rst_addr_ok", data_addr_ok, 1'b1);
    check("mid_rst_rdata", data_rdata, 32'h0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    check("post_rst_addr_ok", data_addr_ok, 1'b1);
    check("post_rst_rready", rready, 1'b0);
    read_zw(32'h1FC0_0044, 2'd2, 32'h1234_5678);
    read_zw(32'h1FC0_0046, 2'd1, 32'h9ABC_0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/data_sram_axi_bridge.md
Name: data_sram_axi_bridge

Overview:
Converts the CPU core's SRAM-like data port (req / addr_ok / data_ok handshake) into single-beat AXI master transactions. It sits directly downstream of the CPU top's data port and upstream of the AXI interconnect. It handles one transaction at a time and stalls the core through addr_ok / data_ok.

Parameters:
ADDR_W, 32, address width of both sides
DATA_W, 32, data width of both sides; strobe width is DATA_W/8

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
data_req  in  1  CPU requests a transaction
data_wr  in  1  1 = write, 0 = read
data_size  in  2  0 = byte, 1 = halfword, 2 = word
data_addr  in  ADDR_W  physical byte address
data_wdata  in  DATA_W  write data, already lane-aligned by the core
data_addr_ok  out  1  request accepted this cycle
data_data_ok  out  1  transaction complete (one-cycle pulse)
data_rdata  out  DATA_W  read data, valid with data_data_ok
araddr  out  ADDR_W  AR address
arlen  out  8  constant 0
arsize  out  3  {1'b0, size}
arvalid  out  1  AR valid
arready  in  1  AR ready
rdata  in  DATA_W  R data
rlast  in  1  R last (always 1; ignored)
rvalid  in  1  R valid
rready  out  1  R ready
awaddr  out  ADDR_W  AW address
awlen  out  8  constant 0
awsize  out  3  {1'b0, size}
awvalid  out  1  AW valid
awready  in  1  AW ready
wdata  out  DATA_W  W data
wstrb  out  DATA_W/8  byte strobes
wlast  out  1  tied 1
wvalid  out  1  W valid
wready  in  1  W ready
bvalid  in  1  B valid
bready  out  1  B ready

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- Reset (asynchronous, resetn = 0):
  - State returns to IDLE.
  - arvalid, awvalid, wvalid, rready, bready, data_data_ok = 0.
  - data_rdata and all latched address/data/size/strobe registers = 0.
  - data_addr_ok = 1 (it is combinational from IDLE).
- data_addr_ok = (state == IDLE).
- Acceptance happens on data_req & data_addr_ok. On acceptance, latch addr, size, wdata and the computed wstrb.
  - Read: go to RD_ADDR.
  - Write: go to WR_REQ.
- wstrb computation:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b0011 << {addr[1], 1'b0}.
  - size 2: 4'b1111.
  - size 3 is illegal; treat it as word.
- AXI addresses are issued unmodified; there is no alignment masking.
- RD_ADDR:
  - arvalid = 1, held stable until arready.
  - On the handshake, go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid, register rdata into data_rdata and go to DONE.
- WR_REQ:
  - awvalid and wvalid are both asserted on entry.
  - Each one drops independently after its own handshake; both handshakes may occur in the same cycle.
  - When both are done, go to WR_RESP.
  - Payload stays stable while valid is high.
- WR_RESP:
  - bready = 1.
  - On bvalid, go to DONE.
  - bresp is not observed.
- DONE:
  - data_data_ok = 1 for exactly one cycle; data_addr_ok = 0.
  - Next state is IDLE.
  - data_rdata holds its value until the next read completes.
- Latency with zero-wait slave, from the acceptance cycle to the data_ok cycle:
  - Read: 3 cycles (AR in cycle +1, R in cycle +2, data_ok in cycle +3).
  - Write: 3 cycles.
- Flow control:
  - data_req while not IDLE is ignored; the core must hold its request until addr_ok.
  - data_addr_ok and data_data_ok are never high in the same cycle.
  - At most one outstanding AXI transaction; no read/write reordering.
- Stray R or B beats outside RD_DATA / WR_RESP are not accepted (rready/bready are low).
- resetn asserted mid-transaction: all valids and readies drop immediately (asynchronously) and the in-flight transaction is abandoned. The slave is assumed reset by the same signal.
- No timeout logic.

Test Plan:
- Reset: resetn low for 3 cycles, then released -> all AXI valids/readies 0, data_addr_ok 1, data_data_ok 0, data_rdata 0.
- Word read: addr 0x1FC0_0010, size 2; arready = 1 immediately; rvalid 3 cycles after AR with 0xDEADBEEF -> araddr 0x1FC0_0010, arsize 3'b010, arlen 0; data_data_ok pulses 1 cycle with data_rdata 0xDEADBEEF; addr_ok low from acceptance until the cycle after data_ok.
- Byte write: addr 0x8000_0003, size 0, wdata 0xAB00_0000 -> awaddr 0x8000_0003, awsize 0, wstrb 4'b1000, wlast 1; data_ok one cycle after bvalid & bready.
- Halfword write with awready immediate and wready delayed 4 cycles -> awvalid drops after 1 cycle, wvalid held 5 cycles with stable wdata, wstrb 4'b1100 for addr[1] = 1; bready rises only after the W handshake.
- Back-to-back: second req held high during the first read -> second accepted exactly one cycle after the first data_ok; no AR issued before that.
- resetn pulsed low during RD_DATA with rvalid withheld -> rready and arvalid 0 within the same cycle; after release, state is IDLE and a new read completes normally.
